// File: rtl/sm4_pkg.sv
// Shared SM4 constants and byte/word primitives used by the key schedule.
package sm4_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [0:3][31:0] FK = {
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  localparam logic [0:255][7:0] SBOX = {
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // CK[i] byte j (j=0 is the MS byte) = (4i+j)*7 mod 256
  function automatic logic [31:0] ck_const(input logic [4:0] i);
    int v;
    ck_const = '0;
    for (int j = 0; j < 4; j++) begin
      v = (4 * int'(i) + j) * 7;
      ck_const[31-8*j -: 8] = v[7:0];
    end
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    tau = '0;
    for (int j = 0; j < 4; j++) tau[8*j +: 8] = SBOX[a[8*j +: 8]];
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    l_key = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

endpackage

// File: rtl/SM4_RoundKey.sv
// Combinational SM4 key-schedule step: K4 = K0 ^ L'(tau(K1^K2^K3^CK[counter])).
module SM4_RoundKey
  import sm4_pkg::*;
(
  input  logic [31:0] K0,
  input  logic [31:0] K1,
  input  logic [31:0] K2,
  input  logic [31:0] K3,
  input  logic [4:0]  counter,
  output logic [31:0] K_4
);

  logic [31:0] w_mix;

  assign w_mix = K1 ^ K2 ^ K3 ^ ck_const(counter);
  assign K_4   = K0 ^ l_key(tau(w_mix));

endmodule

// File: rtl/sm4_key_expand.sv
// Iterative SM4 key expansion: one round key per clock into a 32-entry register file
// with a registered, encrypt/decrypt-ordered read port.
module sm4_key_expand
  import sm4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [127:0]     mk,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [4:0]       rd_idx,
  input  logic             rd_rev,
  output logic [WIDTH-1:0] rk
);

  logic [0:0]       r_state;
  logic [4:0]       r_cnt;
  logic [0:3][31:0] r_k;
  logic             r_done;
  logic             r_kv;
  logic [WIDTH-1:0] r_rk;
  logic [WIDTH-1:0] r_mem [32];
  logic [31:0]      w_k4;
  logic [4:0]       w_rd_addr;

  SM4_RoundKey u_step (
    .K0      (r_k[0]),
    .K1      (r_k[1]),
    .K2      (r_k[2]),
    .K3      (r_k[3]),
    .counter (r_cnt),
    .K_4     (w_k4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_kv    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_k[0]  <= mk[127:96] ^ FK[0];
          r_k[1]  <= mk[95:64]  ^ FK[1];
          r_k[2]  <= mk[63:32]  ^ FK[2];
          r_k[3]  <= mk[31:0]   ^ FK[3];
          r_cnt   <= '0;
          r_kv    <= 1'b0;
          r_state <= ST_RUN;
        end
      end else begin
        r_k   <= {r_k[1], r_k[2], r_k[3], w_k4};
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
          r_kv    <= 1'b1;
        end
      end
    end
  end

  // Key storage is deliberately unreset; keys_valid qualifies its contents.
  always_ff @(posedge clk) begin
    if (r_state == ST_RUN) r_mem[r_cnt] <= w_k4;
  end

  assign w_rd_addr = rd_rev ? (5'd31 - rd_idx) : rd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rk <= '0;
    else        r_rk <= r_mem[w_rd_addr];
  end

  assign busy       = (r_state == ST_RUN);
  assign done       = r_done;
  assign keys_valid = r_kv;
  assign rk         = r_rk;

endmodule

// File: tb/tb_sm4_key_expand.sv
// Directed bench: register-file reads are scored through a queue drained by a monitor.
module tb_sm4_key_expand;

  localparam logic [127:0] KEY_STD = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] KEY_ALT = 128'hDEADBEEFCAFEF00D0011223344556677;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          neq;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] mk = '0;
  logic         busy, done, keys_valid;
  logic [4:0]   rd_idx = '0;
  logic         rd_rev = 1'b0;
  logic [31:0]  rk;

  int  n_vec = 0;
  int  n_err = 0;
  sb_t sb_q[$];
  logic rd_req = 1'b0;
  logic rd_req_d = 1'b0;

  sm4_key_expand #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mk(mk),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .rd_idx(rd_idx), .rd_rev(rd_rev), .rk(rk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_req_d <= rd_req;

  // Monitor: a read issued before an edge shows on rk after that edge.
  always @(negedge clk) begin
    if (rd_req_d) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_empty: read data %h with no expectation queued", rk);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        n_vec++;
        if (e.neq ? (rk === e.exp) : (rk !== e.exp)) begin
          n_err++;
          $display("FAIL %s: got %h, required %s%h", e.name, rk, e.neq ? "not " : "", e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [4:0] idx, input logic rev, input logic [31:0] exp,
                    input bit neq, input string name);
    sb_t e;
    e.name = name; e.exp = exp; e.neq = neq;
    sb_q.push_back(e);
    rd_idx = idx; rd_rev = rev; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_start(input logic [127:0] key);
    @(negedge clk);
    start = 1'b1; mk = key;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
  endtask

  task automatic check_std_reads(input string tag);
    rd(5'd0,  1'b0, 32'hF12186F9, 1'b0, {tag, "_rk0"});
    rd(5'd1,  1'b0, 32'h41662B61, 1'b0, {tag, "_rk1"});
    rd(5'd31, 1'b0, 32'h9124A012, 1'b0, {tag, "_rk31"});
    drain();
  endtask

  initial begin
    int n;
    int ndone, tdone;
    int t[$];
    int lowcnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_kv",   32'(keys_valid), 32'd0);
    chk("rst_rk",   rk, 32'd0);
    rst_n = 1'b1;

    // Standard vector, encrypt and decrypt order
    do_start(KEY_STD);
    wait_done(n);
    chk("std_done_lat", n, 32);
    chk("std_kv", 32'(keys_valid), 32'd1);
    chk("std_busy_off", 32'(busy), 32'd0);
    @(negedge clk);
    chk("std_done_fall", 32'(done), 32'd0);
    check_std_reads("enc");
    rd(5'd0,  1'b1, 32'h9124A012, 1'b0, "dec_idx0");
    rd(5'd31, 1'b1, 32'hF12186F9, 1'b0, "dec_idx31");
    rd(5'd30, 1'b1, 32'h41662B61, 1'b0, "dec_idx30");
    drain();

    // start and a different mk during RUN are ignored
    do_start(KEY_STD);
    mk = KEY_ALT;
    ndone = 0; tdone = 0;
    for (int i = 1; i <= 40; i++) begin
      start = (i == 5 || i == 20);
      @(negedge clk);
      if (done) begin ndone++; tdone = i; end
    end
    start = 1'b0;
    chk("ign_done_cnt", ndone, 1);
    chk("ign_done_time", tdone, 32);
    check_std_reads("ign");

    // Back-to-back start on the done cycle
    do_start(KEY_STD);
    wait_done(n);
    chk("b2b_first_lat", n, 32);
    start = 1'b1; mk = '0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_kv_drop", 32'(keys_valid), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(n);
    chk("b2b_second_lat", n, 32);
    chk("b2b_kv", 32'(keys_valid), 32'd1);
    rd(5'd0, 1'b0, 32'hF12186F9, 1'b1, "b2b_rk0_changed");
    drain();

    // Asynchronous reset in the middle of RUN
    do_start(KEY_STD);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_kv",   32'(keys_valid), 32'd0);
    chk("arst_rk",   rk, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(KEY_STD);
    wait_done(n);
    chk("arst_rerun_lat", n, 32);
    check_std_reads("arst");
    rd(5'd31, 1'b1, 32'hF12186F9, 1'b0, "arst_dec31");
    drain();

    // start held high: a new schedule every 33 cycles
    @(negedge clk);
    start = 1'b1; mk = KEY_STD;
    lowcnt = 0;
    for (int i = 1; i <= 105; i++) begin
      @(negedge clk);
      if (done) t.push_back(i);
      if (t.size() == 1 && !busy) lowcnt++;
    end
    start = 1'b0;
    chk("hold_done_cnt", t.size(), 3);
    if (t.size() == 3) begin
      chk("hold_gap1", t[1] - t[0], 33);
      chk("hold_gap2", t[2] - t[1], 33);
    end
    chk("hold_busy_low", lowcnt, 1);
    wait_done(n);
    chk("hold_last_done", 32'(done), 32'd1);
    check_std_reads("hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
